execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the MIPS core. Sits directly downstream of the decode stage and consumes its control fields, sign-extended offset and PC+4.
- Computes ALU results, branch decisions and branch targets. Registers everything into the EX/MEM boundary.
- Contains an iterative 32-cycle multiply/divide unit with HI/LO registers. While that unit is working, it stalls decode through `busy`.

Parameters:
- MD_CYCLES, 32, number of iteration cycles for mult/div. Fixed at 32 for a 32-bit datapath.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  decode presents a valid instruction this cycle
- busy  output  1  mult/div in progress; upstream must hold; inputs ignored while high
- rs_data  input  32  register-file read of rs
- rt_data  input  32  register-file read of rt
- branch_offset  input  32  sign-extended immediate from decode
- shamt  input  5  shift amount
- alu_source  input  1  1: operand B = branch_offset; 0: rt_data
- alu_op  input  4  operation select (encoding below)
- funct  input  6  function field, used when alu_op = 1100
- pc_in  input  32  PC+4 from decode
- branch_flag, mem_to_reg, mem_read, mem_write, reg_write  input  1 each  decode controls
- dest_reg  input  5  write-back register already chosen by reg_dest
- ex_valid  output  1  EX/MEM contents valid
- alu_result  output  32  registered result
- store_data  output  32  registered rt_data
- zero  output  1  registered (A - B == 0)
- branch_taken  output  1  registered branch_flag & (rs_data == rt_data)
- branch_target  output  32  registered pc_in + (branch_offset << 2)
- ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_reg_write  output  1 each  registered controls
- ex_dest_reg  output  5  registered dest_reg

Behaviour:
- Reset: all outputs 0; HI = LO = 0; FSM = IDLE; iteration counter = 0.
- Accept condition: in_valid & ~busy. On an accepting edge every EX/MEM output is loaded and ex_valid = 1. Otherwise ex_valid = 0 and all control outputs are 0; data outputs hold.
- Latency: one cycle for all non-mult/div operations.
- alu_op encoding, with A = rs_data and B = operand B:
  - 0000 AND; 0001 OR; 0010 ADD (wraps, no overflow trap); 0011 XOR; 0100 NOR
  - 0101 SLL B by shamt; 1000 SRL; 1001 SRA (both act on B by shamt)
  - 0110 SUB (wraps); 0111 SLT signed; 1010 SLTU
  - 1011 LUI = {B[15:0], 16'h0}
  - 1100 MULDIV group; 1101–1111 give result 0
- MULDIV group, selected by funct:
  - 0x10 MFHI: result = HI
  - 0x12 MFLO: result = LO
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU: start the FSM. The instruction itself retires with ex_valid = 1 and ex_reg_write forced to 0.
  - Any other funct: result 0.
- FSM states IDLE → RUN → IDLE:
  - Start edge: latch operand magnitudes and sign flags, counter = MD_CYCLES, busy = 1.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per edge, counter decrements.
  - The edge on which counter goes 1→0 writes HI/LO, applies sign correction, clears busy and returns to IDLE.
  - busy is therefore high for exactly 32 cycles. The first instruction accepted after a start is at start edge + 33.
- Arithmetic results:
  - MULT/MULTU: {HI, LO} = 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: LO = 32'hFFFFFFFF, HI = dividend. No trap.
- Simultaneous events:
  - rst has priority over everything; reset mid-RUN aborts and clears HI/LO.
  - MFHI/MFLO cannot be accepted while busy, so they always read the final values.
- branch_taken is evaluated for BEQ semantics only. branch_target is computed regardless of branch_flag.

Test Plan:
- ADD A=0x7FFFFFFF, B=1, alu_source=0 → next cycle alu_result=0x80000000, ex_valid=1, zero=0.
- SLT A=0xFFFFFFFF (-1), B=1 → 1; SLTU with same operands → 0. SRA B=0x80000000, shamt=4 → 0xF8000000.
- BEQ: branch_flag=1, rs=rt=5, pc_in=0x100, offset=0xFFFFFFFE → branch_taken=1, branch_target=0xF8.
- MULT A=-7, B=3 → busy high exactly 32 cycles; following MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB. in_valid pulses during busy produce no ex_valid.
- DIV A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=9, B=0 → LO=0xFFFFFFFF, HI=9.
- Assert rst at cycle 10 of a DIVU → next cycle busy=0, HI=LO=0, all outputs 0; the next instruction is accepted normally.

Source files
------------

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : MIPS execute stage. Computes the ALU result, BEQ decision
//                and branch target, and registers them with the decode
//                controls into the EX/MEM boundary. Contains an iterative
//                multiply/divide unit with HI/LO registers. While that unit
//                iterates, busy stalls decode.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid / busy     - decode handshake (accept = in_valid & ~busy)
//                rs_data, rt_data,
//                branch_offset,
//                shamt, alu_source,
//                alu_op, funct,
//                pc_in               - operands and operation select
//                branch_flag .. dest_reg - decode controls
//                ex_*, alu_result, store_data, zero,
//                branch_taken, branch_target - registered EX/MEM outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        busy,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] branch_offset,
    input  logic [4:0]  shamt,
    input  logic        alu_source,
    input  logic [3:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] pc_in,
    input  logic        branch_flag,
    input  logic        mem_to_reg,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic [4:0]  dest_reg,
    output logic        ex_valid,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic        zero,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic [4:0]  ex_dest_reg
);

    localparam logic [3:0] c_OP_AND    = 4'b0000;
    localparam logic [3:0] c_OP_OR     = 4'b0001;
    localparam logic [3:0] c_OP_ADD    = 4'b0010;
    localparam logic [3:0] c_OP_XOR    = 4'b0011;
    localparam logic [3:0] c_OP_NOR    = 4'b0100;
    localparam logic [3:0] c_OP_SLL    = 4'b0101;
    localparam logic [3:0] c_OP_SUB    = 4'b0110;
    localparam logic [3:0] c_OP_SLT    = 4'b0111;
    localparam logic [3:0] c_OP_SRL    = 4'b1000;
    localparam logic [3:0] c_OP_SRA    = 4'b1001;
    localparam logic [3:0] c_OP_SLTU   = 4'b1010;
    localparam logic [3:0] c_OP_LUI    = 4'b1011;
    localparam logic [3:0] c_OP_MULDIV = 4'b1100;

    localparam logic [5:0] c_FN_MFHI   = 6'h10;
    localparam logic [5:0] c_FN_MFLO   = 6'h12;

    localparam int CNT_W = $clog2(MD_CYCLES + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             r_state_q;
    logic [CNT_W-1:0]   r_cnt_q;
    logic               r_busy_q;
    logic [31:0]        r_hi_q, r_lo_q;
    logic [63:0]        r_p_q;        // mult: {acc, multiplier}; div: {rem, quot}
    logic [31:0]        r_b_q;        // multiplicand / divisor magnitude
    logic               r_div_q;
    logic               r_neg_q_q;    // negate product / quotient
    logic               r_neg_r_q;    // negate remainder
    logic               r_bzero_q;
    logic [31:0]        r_dividend_q;

    logic               r_ex_valid_q, r_zero_q, r_bt_q;
    logic               r_m2r_q, r_mr_q, r_mw_q, r_rw_q;
    logic [31:0]        r_res_q, r_st_q, r_tgt_q;
    logic [4:0]         r_dst_q;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] w_b;
    logic [31:0] w_diff;
    logic [31:0] w_result;
    logic        w_accept;
    logic        w_md_start;
    logic        w_signed_op;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;

    assign w_b      = alu_source ? branch_offset : rt_data;
    assign w_diff   = rs_data - w_b;
    assign w_accept = in_valid & ~r_busy_q;

    // funct 0x18..0x1B start the iterative unit; funct[0]=0 selects signed
    assign w_md_start  = w_accept && (alu_op == c_OP_MULDIV) && (funct[5:2] == 4'b0110);
    assign w_signed_op = ~funct[0];
    assign w_a_neg     = w_signed_op & rs_data[31];
    assign w_b_neg     = w_signed_op & w_b[31];
    assign w_a_mag     = w_a_neg ? (32'd0 - rs_data) : rs_data;
    assign w_b_mag     = w_b_neg ? (32'd0 - w_b) : w_b;

    always_comb begin
        w_result = 32'd0;
        case (alu_op)
            c_OP_AND:  w_result = rs_data & w_b;
            c_OP_OR:   w_result = rs_data | w_b;
            c_OP_ADD:  w_result = rs_data + w_b;
            c_OP_XOR:  w_result = rs_data ^ w_b;
            c_OP_NOR:  w_result = ~(rs_data | w_b);
            c_OP_SLL:  w_result = w_b << shamt;
            c_OP_SUB:  w_result = w_diff;
            c_OP_SLT:  w_result = {31'd0, $signed(rs_data) < $signed(w_b)};
            c_OP_SRL:  w_result = w_b >> shamt;
            c_OP_SRA:  w_result = $signed(w_b) >>> shamt;
            c_OP_SLTU: w_result = {31'd0, rs_data < w_b};
            c_OP_LUI:  w_result = {w_b[15:0], 16'h0000};
            c_OP_MULDIV: begin
                if (funct == c_FN_MFHI)      w_result = r_hi_q;
                else if (funct == c_FN_MFLO) w_result = r_lo_q;
                else                         w_result = 32'd0;
            end
            default:   w_result = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply / divide iteration step
    // ------------------------------------------------------------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_top;       // remainder shifted left with next dividend bit
    logic [33:0] w_div_try;
    logic [63:0] w_div_next;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;

    assign w_mul_sum  = {1'b0, r_p_q[63:32]} + (r_p_q[0] ? {1'b0, r_b_q} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_p_q[31:1]};

    assign w_div_top  = r_p_q[63:31];
    assign w_div_try  = {1'b0, w_div_top} - {2'b00, r_b_q};
    assign w_div_next = w_div_try[33] ? {w_div_top[31:0], r_p_q[30:0], 1'b0}
                                      : {w_div_try[31:0], r_p_q[30:0], 1'b1};

    assign w_step = r_div_q ? w_div_next : w_mul_next;

    // Sign correction applied to the final step's value
    assign w_prod = r_neg_q_q ? (64'd0 - w_step) : w_step;
    assign w_quot = r_neg_q_q ? (32'd0 - w_step[31:0]) : w_step[31:0];
    assign w_rem  = r_neg_r_q ? (32'd0 - w_step[63:32]) : w_step[63:32];

    // ------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_cnt_q      <= '0;
            r_busy_q     <= 1'b0;
            r_hi_q       <= 32'd0;
            r_lo_q       <= 32'd0;
            r_p_q        <= 64'd0;
            r_b_q        <= 32'd0;
            r_div_q      <= 1'b0;
            r_neg_q_q    <= 1'b0;
            r_neg_r_q    <= 1'b0;
            r_bzero_q    <= 1'b0;
            r_dividend_q <= 32'd0;
            r_ex_valid_q <= 1'b0;
            r_res_q      <= 32'd0;
            r_st_q       <= 32'd0;
            r_zero_q     <= 1'b0;
            r_bt_q       <= 1'b0;
            r_tgt_q      <= 32'd0;
            r_m2r_q      <= 1'b0;
            r_mr_q       <= 1'b0;
            r_mw_q       <= 1'b0;
            r_rw_q       <= 1'b0;
            r_dst_q      <= 5'd0;
        end else begin
            // EX/MEM boundary: data holds when idle, controls drop to 0
            if (w_accept) begin
                r_ex_valid_q <= 1'b1;
                r_res_q      <= w_result;
                r_st_q       <= rt_data;
                r_zero_q     <= (w_diff == 32'd0);
                r_bt_q       <= branch_flag & (rs_data == rt_data);
                r_tgt_q      <= pc_in + {branch_offset[29:0], 2'b00};
                r_m2r_q      <= mem_to_reg;
                r_mr_q       <= mem_read;
                r_mw_q       <= mem_write;
                r_rw_q       <= reg_write & ~w_md_start;
                r_dst_q      <= dest_reg;
            end else begin
                r_ex_valid_q <= 1'b0;
                r_bt_q       <= 1'b0;
                r_m2r_q      <= 1'b0;
                r_mr_q       <= 1'b0;
                r_mw_q       <= 1'b0;
                r_rw_q       <= 1'b0;
            end

            case (r_state_q)
                S_IDLE: begin
                    if (w_md_start) begin
                        r_state_q    <= S_RUN;
                        r_busy_q     <= 1'b1;
                        r_cnt_q      <= CNT_W'(MD_CYCLES);
                        r_p_q        <= {32'd0, w_a_mag};
                        r_b_q        <= w_b_mag;
                        r_div_q      <= funct[1];
                        r_neg_q_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r_q    <= w_a_neg;
                        r_bzero_q    <= (w_b == 32'd0);
                        r_dividend_q <= rs_data;
                    end
                end
                S_RUN: begin
                    r_p_q   <= w_step;
                    r_cnt_q <= r_cnt_q - CNT_W'(1);
                    if (r_cnt_q == CNT_W'(1)) begin
                        r_state_q <= S_IDLE;
                        r_busy_q  <= 1'b0;
                        if (!r_div_q) begin
                            r_hi_q <= w_prod[63:32];
                            r_lo_q <= w_prod[31:0];
                        end else if (r_bzero_q) begin
                            r_hi_q <= r_dividend_q;
                            r_lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi_q <= w_rem;
                            r_lo_q <= w_quot;
                        end
                    end
                end
                default: r_state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy_q;
    assign ex_valid      = r_ex_valid_q;
    assign alu_result    = r_res_q;
    assign store_data    = r_st_q;
    assign zero          = r_zero_q;
    assign branch_taken  = r_bt_q;
    assign branch_target = r_tgt_q;
    assign ex_mem_to_reg = r_m2r_q;
    assign ex_mem_read   = r_mr_q;
    assign ex_mem_write  = r_mw_q;
    assign ex_reg_write  = r_rw_q;
    assign ex_dest_reg   = r_dst_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Scoreboard bench for execute_stage. Stimulus pushes the
//                hand-computed response; a monitor pops and compares on
//                every ex_valid cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        busy;
    logic [31:0] rs_data, rt_data, branch_offset, pc_in;
    logic [4:0]  shamt, dest_reg;
    logic        alu_source;
    logic [3:0]  alu_op;
    logic [5:0]  funct;
    logic        branch_flag, mem_to_reg, mem_read, mem_write, reg_write;
    logic        ex_valid, zero, branch_taken;
    logic [31:0] alu_result, store_data, branch_target;
    logic        ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [4:0]  ex_dest_reg;

    always #5 clk = ~clk;

    execute_stage #(.MD_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .busy(busy),
        .rs_data(rs_data), .rt_data(rt_data), .branch_offset(branch_offset),
        .shamt(shamt), .alu_source(alu_source), .alu_op(alu_op), .funct(funct),
        .pc_in(pc_in), .branch_flag(branch_flag), .mem_to_reg(mem_to_reg),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .dest_reg(dest_reg), .ex_valid(ex_valid), .alu_result(alu_result),
        .store_data(store_data), .zero(zero), .branch_taken(branch_taken),
        .branch_target(branch_target), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_dest_reg(ex_dest_reg)
    );

    typedef struct {
        string       nm;
        logic [31:0] res, st, tgt;
        logic        zr, bt, m2r, mr, mw, rw;
        logic [4:0]  dst;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_issue = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every ex_valid must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && ex_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ex_valid: got result 0x%08h expected no output", alu_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.nm, ".result"}, alu_result, e.res);
                chk({e.nm, ".store"},  store_data, e.st);
                chk({e.nm, ".zero"},   {31'd0, zero}, {31'd0, e.zr});
                chk({e.nm, ".taken"},  {31'd0, branch_taken}, {31'd0, e.bt});
                chk({e.nm, ".target"}, branch_target, e.tgt);
                chk({e.nm, ".ctrl"},   {28'd0, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_reg_write},
                                       {28'd0, e.m2r, e.mr, e.mw, e.rw});
                chk({e.nm, ".dest"},   {27'd0, ex_dest_reg}, {27'd0, e.dst});
            end
        end
    end

    // Drive one instruction for one accepting edge and record its response.
    task automatic issue(input string nm, input logic [3:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic src,
                         input logic [31:0] off, input logic [4:0] sh,
                         input logic [31:0] pc, input logic bf,
                         input logic [31:0] exp_res, input logic md_start);
        exp_t e;
        logic [31:0] opb;
        logic [4:0]  tag;
        n_issue++;
        tag = 5'(n_issue);
        rs_data = a; rt_data = b; alu_source = src; branch_offset = off;
        shamt = sh; pc_in = pc; branch_flag = bf; alu_op = op; funct = fn;
        mem_to_reg = tag[0]; mem_read = tag[1]; mem_write = tag[2];
        reg_write = 1'b1; dest_reg = tag;
        in_valid = 1'b1;
        opb   = src ? off : b;
        e.nm  = nm;
        e.res = exp_res;
        e.st  = b;
        e.zr  = (a == opb);
        e.bt  = bf & (a == b);
        e.tgt = pc + (off << 2);
        e.m2r = tag[0]; e.mr = tag[1]; e.mw = tag[2];
        e.rw  = ~md_start;
        e.dst = tag;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count busy cycles (bounded); junk in_valid pulses must all be ignored.
    task automatic wait_busy(input string nm, input int expected);
        int cnt;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            in_valid = cnt[0];
            rs_data  = 32'(cnt);
            alu_op   = 4'b0010;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk({nm, ".busy_cycles"}, 32'(cnt), 32'(expected));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        rs_data = '0; rt_data = '0; branch_offset = '0; shamt = '0; pc_in = '0;
        alu_source = 1'b0; alu_op = '0; funct = '0; dest_reg = '0;
        branch_flag = 1'b0; mem_to_reg = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.outputs", {busy, ex_valid, zero, branch_taken, ex_mem_to_reg, ex_mem_read,
                              ex_mem_write, ex_reg_write, 24'd0}, 32'd0);
        chk("reset.result", alu_result | store_data | branch_target, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        //    name     op       fn     A             B             src  off           sh  pc        bf  expected      md
        issue("add",   4'b0010, 6'h00, 32'h7FFFFFFF, 32'h00000001, 0, 32'h00000000, 0,  32'h0,    0, 32'h80000000, 0);
        issue("slt",   4'b0111, 6'h00, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000001, 0);
        issue("sltu",  4'b1010, 6'h00, 32'hFFFFFFFF, 32'h00000001, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000000, 0);
        issue("sra",   4'b1001, 6'h00, 32'h00000000, 32'h80000000, 0, 32'h00000000, 4,  32'h0,    0, 32'hF8000000, 0);
        issue("srl",   4'b1000, 6'h00, 32'h00000000, 32'h80000000, 0, 32'h00000000, 4,  32'h0,    0, 32'h08000000, 0);
        issue("beq",   4'b0110, 6'h00, 32'h00000005, 32'h00000005, 0, 32'hFFFFFFFE, 0,  32'h100,  1, 32'h00000000, 0);
        issue("and",   4'b0000, 6'h00, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'h00000000, 0,  32'h0,    0, 32'hF000F000, 0);
        issue("nor",   4'b0100, 6'h00, 32'h0F0F0000, 32'h00F0000F, 0, 32'h00000000, 0,  32'h0,    0, 32'hF000FFF0, 0);
        issue("lui",   4'b1011, 6'h00, 32'h00000000, 32'h0000AAAA, 1, 32'h00001234, 0,  32'h40,   0, 32'h12340000, 0);
        issue("sll",   4'b0101, 6'h00, 32'h00000000, 32'h00000001, 0, 32'h00000000, 31, 32'h0,    0, 32'h80000000, 0);
        issue("sub",   4'b0110, 6'h00, 32'h00000000, 32'h00000001, 0, 32'h00000000, 0,  32'h0,    1, 32'hFFFFFFFF, 0);
        issue("op1101",4'b1101, 6'h00, 32'h12345678, 32'h00000001, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000000, 0);
        issue("xor",   4'b0011, 6'h00, 32'hFFFF0000, 32'hFF00FF00, 0, 32'h00000000, 0,  32'h0,    0, 32'h00FFFF00, 0);

        issue("mult",  4'b1100, 6'h18, 32'hFFFFFFF9, 32'h00000003, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000000, 1);
        wait_busy("mult", 32);
        issue("mfhi1", 4'b1100, 6'h10, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'hFFFFFFFF, 0);
        issue("mflo1", 4'b1100, 6'h12, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'hFFFFFFEB, 0);

        issue("div",   4'b1100, 6'h1A, 32'hFFFFFFF9, 32'h00000002, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000000, 1);
        wait_busy("div", 32);
        issue("mflo2", 4'b1100, 6'h12, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'hFFFFFFFD, 0);
        issue("mfhi2", 4'b1100, 6'h10, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'hFFFFFFFF, 0);

        issue("multu", 4'b1100, 6'h19, 32'hFFFFFFFF, 32'h00000002, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000000, 1);
        wait_busy("multu", 32);
        issue("mfhi3", 4'b1100, 6'h10, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h00000001, 0);
        issue("mflo3", 4'b1100, 6'h12, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'hFFFFFFFE, 0);

        issue("divu0", 4'b1100, 6'h1B, 32'h00000009, 32'h00000000, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000000, 1);
        wait_busy("divu0", 32);
        issue("mflo4", 4'b1100, 6'h12, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'hFFFFFFFF, 0);
        issue("mfhi4", 4'b1100, 6'h10, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h00000009, 0);

        // Reset in the middle of a DIVU aborts it and clears HI/LO
        issue("divu",  4'b1100, 6'h1B, 32'h00000064, 32'h00000007, 0, 32'h00000000, 0,  32'h0,    0, 32'h00000000, 1);
        repeat (9) @(posedge clk);
        #1;
        chk("divu.busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst.flags", {busy, ex_valid, zero, branch_taken, ex_mem_to_reg, ex_mem_read,
                          ex_mem_write, ex_reg_write, 24'd0}, 32'd0);
        chk("rst.data", alu_result | store_data | branch_target | {27'd0, ex_dest_reg}, 32'd0);
        issue("mfhi5", 4'b1100, 6'h10, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h00000000, 0);
        issue("mflo5", 4'b1100, 6'h12, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h00000000, 0);
        issue("add2",  4'b0010, 6'h00, 32'h00000002, 32'h00000003, 0, 32'h0, 0, 32'h0, 0, 32'h00000005, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time guard
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
